// File: rtl/fb_write_arbiter.sv
// ============================================================================
// Module  : fb_write_arbiter
// Brief   : Round-robin owner of the framebuffer write port with a
//           vblank-aligned full-screen clear engine.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_write_arbiter #(
    parameter int FB_SIZE = 76800,
    parameter int ADDR_W  = 17
) (
    input  logic              inp_clock,
    input  logic              inp_reset,
    input  logic              inp_vblank,
    input  logic              inp_a_valid,
    input  logic [ADDR_W-1:0] inp_a_addr,
    input  logic [7:0]        inp_a_data,
    output logic              out_a_ready,
    input  logic              inp_b_valid,
    input  logic [ADDR_W-1:0] inp_b_addr,
    input  logic [7:0]        inp_b_data,
    output logic              out_b_ready,
    input  logic              inp_clear_req,
    input  logic [7:0]        inp_clear_color,
    output logic              out_clear_busy,
    output logic              out_clear_done,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_CLEAR   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);
    localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(FB_SIZE);

    state_t            state_q, state_d;
    logic              last_b_q, last_b_d;
    logic              vblank_q;
    logic [7:0]        color_q, color_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              a_ready, b_ready, vblank_rise;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        // Readiness is held low while reset is asserted, not just after it.
        if (inp_reset && (state_q != ST_CLEAR)) begin
            a_ready = inp_a_valid && (!inp_b_valid || last_b_q);
            b_ready = inp_b_valid && (!inp_a_valid || !last_b_q);
        end
    end

    always_comb begin
        vblank_rise = inp_vblank && !vblank_q;
        state_d     = state_q;
        color_d     = color_q;
        cnt_d       = cnt_q;
        last_b_d    = last_b_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inp_clear_req) begin
                    state_d = ST_PENDING;
                    color_d = inp_clear_color;
                end
            end
            ST_PENDING: begin
                if (inp_clear_req) color_d = inp_clear_color;
                if (vblank_rise) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = color_q;
                if (cnt_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Out-of-range writes are consumed and still rotate priority.
        if (a_ready) begin
            last_b_d = 1'b0;
            if ({1'b0, inp_a_addr} < ADDR_LIM) begin
                we_d   = 1'b1;
                addr_d = inp_a_addr;
                data_d = inp_a_data;
            end
        end else if (b_ready) begin
            last_b_d = 1'b1;
            if ({1'b0, inp_b_addr} < ADDR_LIM) begin
                we_d   = 1'b1;
                addr_d = inp_b_addr;
                data_d = inp_b_data;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge inp_clock or negedge inp_reset) begin
        if (!inp_reset) begin
            state_q  <= ST_IDLE;
            last_b_q <= 1'b1;
            vblank_q <= 1'b0;
            color_q  <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            vblank_q <= inp_vblank;
            color_q  <= color_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign out_a_ready    = a_ready;
    assign out_b_ready    = b_ready;
    assign out_we         = we_q;
    assign out_addr       = addr_q;
    assign out_data       = data_q;
    assign out_clear_busy = busy_q;
    assign out_clear_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
// ============================================================================
// Module  : tb_fb_write_arbiter
// Brief   : Directed bench with a behavioural framebuffer-port model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fb_write_arbiter;

    localparam int FB = 76800;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        a_valid, b_valid;
    logic [16:0] a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_ready, b_ready;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        busy, done, we;
    logic [16:0] addr;
    logic [7:0]  data;

    int n_cmp = 0;
    int n_bad = 0;

    fb_write_arbiter #(.FB_SIZE(FB), .ADDR_W(17)) dut (
        .inp_clock      (clk),
        .inp_reset      (rst),
        .inp_vblank     (vblank),
        .inp_a_valid    (a_valid),
        .inp_a_addr     (a_addr),
        .inp_a_data     (a_data),
        .out_a_ready    (a_ready),
        .inp_b_valid    (b_valid),
        .inp_b_addr     (b_addr),
        .inp_b_data     (b_data),
        .out_b_ready    (b_ready),
        .inp_clear_req  (clear_req),
        .inp_clear_color(clear_color),
        .out_clear_busy (busy),
        .out_clear_done (done),
        .out_we         (we),
        .out_addr       (addr),
        .out_data       (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: mode 0 idle, 1 clear waiting for vblank edge, 2 clearing.
    int m_mode, m_last_b, m_vb, m_idx, m_color;
    int e_we, e_addr, e_data, e_busy, e_done;

    always @(negedge clk) begin
        int ra, rb;
        if (!rst) begin
            check("rst_a_ready", a_ready, 0);
            check("rst_b_ready", b_ready, 0);
            check("rst_we", we, 0);
            check("rst_addr", addr, 0);
            check("rst_data", data, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            m_mode = 0; m_last_b = 1; m_vb = 0; m_idx = 0; m_color = 0;
            e_we = 0; e_addr = 0; e_data = 0; e_busy = 0; e_done = 0;
        end else begin
            ra = (m_mode != 2) && a_valid && (!b_valid || m_last_b == 1);
            rb = (m_mode != 2) && b_valid && (!a_valid || m_last_b == 0);
            check("cmp_a_ready", a_ready, ra);
            check("cmp_b_ready", b_ready, rb);
            check("cmp_we", we, e_we);
            check("cmp_addr", addr, e_addr);
            check("cmp_data", data, e_data);
            check("cmp_busy", busy, e_busy);
            check("cmp_done", done, e_done);

            e_done = 0;
            if (m_mode == 2) begin
                e_we = 1; e_addr = m_idx; e_data = m_color;
                if (m_idx == FB - 1) begin
                    e_done = 1;
                    m_mode = 0;
                end else begin
                    m_idx++;
                end
            end else begin
                e_we = 0;
                if (ra) begin
                    m_last_b = 0;
                    if (int'(a_addr) < FB) begin e_we = 1; e_addr = a_addr; e_data = a_data; end
                end else if (rb) begin
                    m_last_b = 1;
                    if (int'(b_addr) < FB) begin e_we = 1; e_addr = b_addr; e_data = b_data; end
                end
                if (clear_req) m_color = clear_color;
                if (m_mode == 1 && vblank && m_vb == 0) begin
                    m_mode = 2;
                    m_idx  = 0;
                end else if (m_mode == 0 && clear_req) begin
                    m_mode = 1;
                end
            end
            e_busy = (m_mode != 0);
            m_vb   = vblank;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n33, leak, seen;
        rst = 1'b0; vblank = 1'b0; clear_req = 1'b0; clear_color = 8'h00;
        a_valid = 1'b1; a_addr = 17'd5; a_data = 8'h11;
        b_valid = 1'b0; b_addr = '0; b_data = '0;

        // Reset with A pending, then first grant and its write.
        @(negedge clk);
        check("t1_ready_in_reset", a_ready, 0);
        check("t1_we_in_reset", we, 0);
        step(); rst = 1'b1;
        @(negedge clk);
        check("t1_a_ready", a_ready, 1);
        step(); a_valid = 1'b0;
        @(negedge clk);
        check("t1_we", we, 1);
        check("t1_addr", addr, 5);
        check("t1_data", data, 8'h11);

        // Fresh reset, then both requesters continuously.
        step(); rst = 1'b0;
        step(); rst = 1'b1;
        a_valid = 1'b1; a_addr = 17'd10; a_data = 8'hA0;
        b_valid = 1'b1; b_addr = 17'd20; b_data = 8'hB0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t2_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            check("t2_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
            step();
        end

        // B alone three times, then A wins the tie.
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_b_only", b_ready, 1);
            step();
        end
        a_valid = 1'b1;
        @(negedge clk);
        check("t3_a_tie", a_ready, 1);
        check("t3_b_tie", b_ready, 0);
        step(); a_valid = 1'b0; b_valid = 1'b0;

        // Out-of-range followed by last valid address.
        a_valid = 1'b1; a_addr = 17'd76800; a_data = 8'h66;
        @(negedge clk);
        check("t4_ready_oor", a_ready, 1);
        step(); a_addr = 17'd76799; a_data = 8'h77;
        @(negedge clk);
        check("t4_ready_last", a_ready, 1);
        check("t4_we_oor", we, 0);
        step(); a_valid = 1'b0;
        @(negedge clk);
        check("t4_we_last", we, 1);
        check("t4_addr_last", addr, 76799);
        check("t4_data_last", data, 8'h77);

        // Two clear requests before vblank; the second colour wins.
        step(); a_valid = 1'b1; a_addr = 17'd7; a_data = 8'h44;
        clear_req = 1'b1; clear_color = 8'h22;
        step(); clear_req = 1'b0;
        step(); clear_req = 1'b1; clear_color = 8'h33;
        step(); clear_req = 1'b0;
        step();
        step(); vblank = 1'b1;
        n33 = 0; leak = 0; seen = 0;
        for (int i = 0; i < 80000 && seen == 0; i++) begin
            @(negedge clk);
            if (we && data == 8'h33) n33++;
            if (done) seen = 1;
            else if (n33 > 0 && (a_ready || b_ready)) leak++;
            if (seen == 0) step();
        end
        check("t5_done_seen", seen, 1);
        check("t5_write_count", n33, 76800);
        check("t5_ready_leak", leak, 0);
        check("t5_done_addr", addr, 76799);
        check("t5_busy_at_done", busy, 0);
        check("t5_a_ready_at_done", a_ready, 1);
        step();
        @(negedge clk);
        check("t5_b2b_we", we, 1);
        check("t5_b2b_addr", addr, 7);
        check("t5_b2b_data", data, 8'h44);
        step(); a_valid = 1'b0; vblank = 1'b0;

        // Reset in the middle of a clear.
        step(); clear_req = 1'b1; clear_color = 8'h55;
        step(); clear_req = 1'b0;
        step(); vblank = 1'b1;
        repeat (1001) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_we_abort", we, 0);
        check("t6_busy_abort", busy, 0);
        check("t6_done_abort", done, 0);
        step(); rst = 1'b1; vblank = 1'b0;
        step(); step(); step(); vblank = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_no_restart_busy", busy, 0);
            check("t6_no_restart_we", we, 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns the single write port of the 320x240x8 framebuffer bitmap that the VGA scan-out reads.
- Shares that port between two requesters: A (CPU bus bridge) and B (blitter), using round-robin arbitration.
- Contains a built-in clear engine that floods the whole framebuffer with one palette index.
- A clear starts only at the next start of vertical blanking, so a cleared frame never tears mid-scan.

Parameters:
- FB_SIZE, 76800, number of framebuffer bytes (320*240); valid addresses 0..FB_SIZE-1.
- ADDR_W, 17, framebuffer address width; must satisfy 2**ADDR_W >= FB_SIZE.

Ports:
- inp_clock  in  1  pixel/system clock, rising-edge.
- inp_reset  in  1  asynchronous, active-low reset.
- inp_vblank  in  1  high while the scan-out is outside the active area, synchronous to inp_clock.
- inp_a_valid  in  1  requester A has a write pending.
- inp_a_addr  in  ADDR_W  requester A byte address.
- inp_a_data  in  8  requester A pixel index.
- out_a_ready  out  1  A's write is accepted this cycle.
- inp_b_valid  in  1  requester B has a write pending.
- inp_b_addr  in  ADDR_W  requester B byte address.
- inp_b_data  in  8  requester B pixel index.
- out_b_ready  out  1  B's write is accepted this cycle.
- inp_clear_req  in  1  single-cycle pulse requesting a full-framebuffer clear.
- inp_clear_color  in  8  palette index to clear with; sampled with inp_clear_req.
- out_clear_busy  out  1  a clear is pending or running.
- out_clear_done  out  1  one-cycle pulse when a clear completes.
- out_we  out  1  framebuffer write enable, registered.
- out_addr  out  ADDR_W  framebuffer write address, registered.
- out_data  out  8  framebuffer write data, registered.

Behaviour:
- Reset is asynchronous, active-low on inp_reset, clocked by inp_clock. While inp_reset=0, all of the following hold:
  - out_we=0, out_addr=0, out_data=0.
  - out_clear_busy=0, out_clear_done=0.
  - State=IDLE, pending flag=0, last_grant=B (so A wins the first tie), vblank history register=0.
- Reset asserted mid-clear aborts the clear with no done pulse.
- States:
  - IDLE: arbitration active.
  - PENDING: a clear is latched; arbitration stays active; waiting for the vblank rising edge.
  - CLEAR: arbitration is blocked.
- Transitions:
  - IDLE -> PENDING on inp_clear_req.
  - PENDING -> CLEAR on the cycle where inp_vblank=1 and vblank_q=0.
  - CLEAR -> IDLE after the write to FB_SIZE-1 is issued.
- Clear requests:
  - inp_clear_req in PENDING overwrites the latched colour; the last request wins.
  - inp_clear_req in CLEAR is ignored.
  - inp_clear_req in IDLE coincident with a vblank rising edge only enters PENDING; CLEAR starts at the next frame's edge.
- Arbitration (IDLE/PENDING only) is combinational ready:
  - Only one requester valid: that requester gets ready.
  - Both valid: the requester not equal to last_grant gets ready.
  - A transfer is valid&&ready; last_grant updates to the winner on each transfer.
  - At most one ready is high per cycle.
  - Both readys are 0 in CLEAR.
  - ready never depends on the ready of the other requester.
- Write latency: a transfer in cycle N drives out_we=1 with that addr/data in cycle N+1. With no transfer, out_we=0 and out_addr/out_data hold their last values.
- Out-of-range address (addr >= FB_SIZE): the transfer is still accepted (ready=1) and last_grant is updated, but out_we stays 0 for it.
- CLEAR timing:
  - The clear counter starts at 0.
  - Each cycle drives out_we=1, out_addr=counter, out_data=latched colour (registered, 1-cycle latency as above).
  - The first clear write appears the cycle after entering CLEAR.
  - Exactly FB_SIZE consecutive write cycles, address 0..FB_SIZE-1 ascending, no gaps.
  - out_clear_done pulses in the cycle the last write (addr FB_SIZE-1) is on the port.
  - Arbitration resumes in that same cycle, so a requester write can follow back-to-back in the next cycle.
- out_clear_busy = (state != IDLE), registered alongside the state.
- Width rules: the clear counter is ADDR_W bits and is compared against FB_SIZE-1, never relying on wrap.

Test Plan:
- Reset with A valid (addr 5, data 0x11): out_a_ready=0 and outputs 0 during reset; after release, ready=1 in the first cycle and next cycle out_we=1, out_addr=5, out_data=0x11.
- A and B both valid continuously for 6 cycles: grants alternate A,B,A,B,A,B; out_we high every cycle from cycle 2 onward.
- Only B valid for 3 cycles, then A and B valid together: B granted 3 times, then A wins the tie.
- A writes addr 76800 then addr 76799: both accepted; out_we=0 for the first, out_we=1 with addr 76799 for the second.
- clear_req with colour 0x22, then clear_req with colour 0x33 before vblank, then vblank rises:
  - Exactly 76800 writes of 0x33 at addresses 0..76799 back-to-back.
  - readys are 0 throughout.
  - done pulses with addr 76799 on the port; busy drops with it.
- Reset asserted after 1000 clear writes: out_we=0 immediately, busy=0, no done; the next vblank rise without a new request starts no clear.
